// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit
// ----------------------------------------------------------------------------
// Instruction-fetch / program-counter stage in front of the control decoder.
// It owns the program counter, fetches one word at a time from instruction
// memory over a req/ready handshake and holds the word in an instruction
// register. The decoder sees opcode and funct. Once the execute stage reports
// exec_done, the decoder's jump/beq/bne and the ALU zero flag select the next
// PC.
//
// Sequencing: IDLE -> FETCH -> EXEC -> FETCH -> EXEC ...
//   IDLE  : one cycle after reset, then on to FETCH.
//   FETCH : imem_req=1 and imem_addr=pc, held until imem_ready. On that edge
//           the word is captured into instr.
//   EXEC  : instr_valid=1. Waits for exec_done. On that edge pc advances to
//           next_pc and retire_cnt increments.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   imem_req/addr          fetch request and address (address = pc)
//   imem_ready/rdata       memory accept and the fetched word (same cycle)
//   instr, instr_valid     instruction register and its valid flag
//   opcode, funct          instr[31:26] and instr[5:0]
//   jump, beq, bne, zero   decoder controls and ALU zero, sampled on exec_done
//   exec_done              execute stage has finished the current instruction
//   pc, pc_plus4           current instruction address and pc + 4
//   retire_cnt             number of completed instructions (wraps)
//
// All registered outputs depend only on state and instr. No input reaches an
// output combinationally. pc_plus4 is a function of pc alone.
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,

    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,

    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic        exec_done,

    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // The low two bits are forced to zero so that the PC stays word-aligned
    // even if the parameter is misconfigured.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retire_q;
    logic        req_q;
    logic        valid_q;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] next_pc;

    // ------------------------------------------------------------------------
    // Next-PC datapath. Every sum is 32 bits wide, so wraparound is modulo 2^32.
    // ------------------------------------------------------------------------
    assign pc_plus4_w    = pc_q + 32'd4;

    // Sign-extended 16-bit word offset, turned into a byte offset.
    assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branch_target = pc_plus4_w + branch_offset;

    // Pseudo-direct jump: keep the region bits of pc+4 and take a 26-bit word index.
    assign jump_target   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};

    // When beq and bne are both set, zero decides which one applies.
    assign branch_taken  = (beq && zero) || (bne && !zero);

    always_comb begin
        // NOTE: give every always_comb output a default value first. A path that leaves it unassigned would infer a latch.
        next_pc = pc_plus4_w;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM. The handshake flags are registered next to the state, so
    // they change only on clock edges and never follow an input combinationally.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments. All of them then update together at the edge, whatever order they are written in.
            state    <= IDLE;
            pc_q     <= RESET_PC_ALIGNED;
            instr_q  <= '0;
            retire_q <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end

                FETCH: begin
                    // Wait states last as long as memory needs. The request
                    // and address stay stable because pc does not move here.
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state   <= EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end

                EXEC: begin
                    // jump/beq/bne/zero are meaningful only alongside exec_done.
                    if (exec_done) begin
                        pc_q     <= next_pc;
                        retire_q <= retire_q + 32'd1;
                        state    <= FETCH;
                        req_q    <= 1'b1;
                        valid_q  <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit. The expected instruction word and the
// expected next PC are pushed to queues when the stimulus is driven. They are
// popped and compared when the DUT presents the result.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        jump = 1'b0;
    logic        beq = 1'b0;
    logic        bne = 1'b0;
    logic        zero = 1'b0;
    logic        exec_done = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];

    // Reference model state
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_retire = 32'h0;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .funct      (funct),
        .jump       (jump),
        .beq        (beq),
        .bne        (bne),
        .zero       (zero),
        .exec_done  (exec_done),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next_pc(input logic j, input logic b, input logic bn,
                                                  input logic z);
        logic [31:0] seq;
        logic [31:0] off;
        seq = m_pc + 32'd4;
        off = {{16{m_instr[15]}}, m_instr[15:0]} * 32'd4;
        if (j)                          return {seq[31:28], m_instr[25:0], 2'b00};
        else if ((b && z) || (bn && !z)) return seq + off;
        else                            return seq;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        m_instr = 32'h0;
        m_retire = 32'h0;
        exp_instr_q.delete();
        exp_pc_q.delete();
    endtask

    // Called on a negedge. Waits (bounded) for the request, holds off for
    // 'waits' cycles, then returns a word.
    task automatic fetch(input logic [31:0] rdata, input int waits);
        int budget = 0;
        while (imem_req !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = ~rdata;
            @(negedge clk);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_instr", instr, m_instr);
        end
        imem_ready = 1'b1;
        imem_rdata = rdata;
        exp_instr_q.push_back(rdata);
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        m_instr = rdata;
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_req_low", 32'(imem_req), 32'd0);
        if (exp_instr_q.size() > 0) check("instr", instr, exp_instr_q.pop_front());
        else check("instr_queue", 32'(exp_instr_q.size()), 32'd1);
        check("opcode", 32'(opcode), 32'(rdata[31:26]));
        check("funct", 32'(funct), 32'(rdata[5:0]));
    endtask

    // Called on a negedge in EXEC. Stalls 'delay' cycles with noisy flags,
    // then completes the instruction.
    task automatic execute(input logic j, input logic b, input logic bn, input logic z,
                           input int delay);
        logic [31:0] npc;
        for (int i = 0; i < delay; i++) begin
            exec_done = 1'b0;
            jump = 1'($urandom);
            beq = 1'($urandom);
            bne = 1'($urandom);
            zero = 1'($urandom);
            @(negedge clk);
            check("exec_hold", 32'(instr_valid), 32'd1);
        end
        npc = model_next_pc(j, b, bn, z);
        exp_pc_q.push_back(npc);
        exec_done = 1'b1;
        jump = j;
        beq = b;
        bne = bn;
        zero = z;
        @(negedge clk);
        exec_done = 1'b0;
        jump = 1'b0;
        beq = 1'b0;
        bne = 1'b0;
        zero = 1'b0;
        m_pc = npc;
        m_retire = m_retire + 32'd1;
        if (exp_pc_q.size() > 0) check("next_pc", pc, exp_pc_q.pop_front());
        else check("pc_queue", 32'(exp_pc_q.size()), 32'd1);
        check("retire_cnt", retire_cnt, m_retire);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("refetch_req", 32'(imem_req), 32'd1);
        check("refetch_valid", 32'(instr_valid), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_retire"}, retire_cnt, 32'h0);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, 32'h0);
    endtask

    initial begin
        // ---------------- reset and first fetch ----------------
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        #1;
        check("req_cycle1", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("req_cycle2", 32'(imem_req), 32'd1);
        check("addr_cycle2", imem_addr, 32'h0);

        fetch(32'h0022_1820, 0);
        check("add_opcode", 32'(opcode), 32'h0);
        check("add_funct", 32'(funct), 32'h20);
        execute(1'b0, 1'b0, 1'b0, 1'b0, 1);
        check("seq_pc4", pc, 32'h4);
        check("seq_retire1", retire_cnt, 32'h1);

        // ---------------- wait states ----------------
        fetch(32'h2000_0001, 3);
        execute(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("seq_pc8", pc, 32'h8);

        // ---------------- branches ----------------
        fetch(32'h1000_FFFE, 0);
        execute(1'b0, 1'b1, 1'b0, 1'b1, 2);
        check("beq_taken", pc, 32'h4);
        fetch(32'h0000_0000, 1);
        execute(1'b0, 1'b0, 1'b0, 1'b0, 0);
        fetch(32'h1000_FFFE, 0);
        execute(1'b0, 1'b1, 1'b0, 1'b0, 0);
        check("beq_not_taken", pc, 32'hC);
        fetch(32'h0800_0002, 0);
        execute(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("jump_to_8", pc, 32'h8);
        fetch(32'h1400_FFFE, 0);
        execute(1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("bne_taken", pc, 32'h4);
        fetch(32'h1000_0003, 0);
        execute(1'b0, 1'b1, 1'b1, 1'b0, 0);
        check("beq_bne_zero0", pc, 32'h14);

        // ---------------- jumps and region crossing ----------------
        fetch(32'h0BFF_FFFF, 0);
        execute(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("jump_max", pc, 32'h0FFF_FFFC);
        fetch(32'h0000_0000, 0);
        execute(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("region_cross", pc, 32'h1000_0000);
        fetch(32'h0800_0271, 0);
        execute(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("jump_271", pc, 32'h1000_09C4);
        fetch(32'h0800_0010, 0);
        execute(1'b1, 1'b1, 1'b0, 1'b1, 0);
        check("jump_over_beq", pc, 32'h1000_0040);

        // ---------------- stray inputs ----------------
        exec_done = 1'b1;
        jump = 1'b1;
        imem_ready = 1'b0;
        @(negedge clk);
        exec_done = 1'b0;
        jump = 1'b0;
        check("stray_done_pc", pc, m_pc);
        check("stray_done_retire", retire_cnt, m_retire);
        check("stray_done_req", 32'(imem_req), 32'd1);
        fetch(32'h0000_0020, 0);
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ready = 1'b0;
        check("stray_ready_instr", instr, 32'h0000_0020);
        check("stray_ready_valid", 32'(instr_valid), 32'd1);
        execute(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("after_stray_pc", pc, 32'h1000_0044);

        // ---------------- reset mid-EXEC ----------------
        fetch(32'h0000_0025, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_exec");
        @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("late_ready_instr", instr, 32'h0);
        check("late_ready_req", 32'(imem_req), 32'd1);

        // ---------------- wrap-around ----------------
        fetch(32'h1000_FFFE, 0);
        execute(1'b0, 1'b1, 1'b0, 1'b1, 0);
        check("neg_wrap", pc, 32'hFFFF_FFFC);
        check("pc_plus4_wrap", pc_plus4, 32'h0);
        fetch(32'h0000_0000, 0);
        execute(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("seq_wrap", pc, 32'h0);
        check("retire_after_wrap", retire_cnt, 32'h2);

        // ---------------- reset mid-FETCH ----------------
        imem_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_fetch_req", 32'(imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_fetch");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
